// File: rtl/plot_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// plot_arbiter_pkg
// Shared definitions for the pixel-plot arbiter and the game blocks that feed
// it: default coordinate/colour widths, screen bounds, colour constants,
// channel index assignments, the arbitration mode type and a helper for
// sizing channel index fields.
// -----------------------------------------------------------------------------
package plot_arbiter_pkg;

  // Default widths for the 160x120, 3-bit colour VGA adapter
  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 7;
  localparam int DEF_C_W = 3;

  // Visible screen area
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  // Colours used by the game blocks (RGB bit order)
  localparam logic [DEF_C_W-1:0] COLOUR_BLACK = 3'd0;
  localparam logic [DEF_C_W-1:0] COLOUR_SNAKE = 3'd2;
  localparam logic [DEF_C_W-1:0] COLOUR_FOOD  = 3'd4;

  // Fixed channel assignments on the arbiter
  localparam int CH_SNAKE = 0;
  localparam int CH_FOOD  = 1;

  // Arbitration mode: fixed priority (channel 0 highest) or round-robin
  typedef enum logic {
    ARB_FIXED       = 1'b0,
    ARB_ROUND_ROBIN = 1'b1
  } arb_mode_e;

  // Width of a field able to hold a channel index 0..n-1 (at least 1 bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plot_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// plot_arbiter_rr_pick
// Purely combinational one-hot picker. The request vector is rotated so that
// the search start index lands on bit 0, the lowest set bit is isolated, and
// the result is rotated back. In fixed mode the start index is forced to 0,
// which turns the same datapath into a plain lowest-index-wins encoder.
//
// Ports:
//   req    in  N_CH   request vector
//   start  in  IDX_W  channel index where the search begins
//   mode   in  1      ARB_ROUND_ROBIN uses start, ARB_FIXED ignores it
//   grant  out N_CH   one-hot winner, all zero when no request
// -----------------------------------------------------------------------------
module plot_arbiter_rr_pick
  import plot_arbiter_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int IDX_W = idx_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] start,
  input  arb_mode_e        mode,
  output logic [N_CH-1:0]  grant
);

  logic [IDX_W-1:0] eff_start;
  logic [N_CH-1:0]  req_rot;
  logic [N_CH-1:0]  pick_rot;

  assign eff_start = (mode == ARB_ROUND_ROBIN) ? start : '0;

  // Rotate requests so the start channel sits at bit 0, keep only the lowest
  // set bit of the rotated vector, then undo the rotation to get the grant.
  // The downward scan lets the last (lowest) hit overwrite earlier ones.
  always_comb begin
    req_rot  = '0;
    pick_rot = '0;
    grant    = '0;
    for (int k = 0; k < N_CH; k++) begin
      req_rot[k] = req[(int'(eff_start) + k) % N_CH];
    end
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_rot    = '0;
        pick_rot[k] = 1'b1;
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      grant[(int'(eff_start) + k) % N_CH] = pick_rot[k];
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// -----------------------------------------------------------------------------
// plot_arbiter
// Merges pixel-plot requests from N_CH game sub-blocks onto the single VGA
// adapter write port. Requests are level signals held until acknowledged, so
// no pixel is dropped when several writers want the port in the same cycle.
// One channel is granted per cycle (round-robin or fixed priority), its pixel
// is registered onto the output one cycle later, and any other requester
// aiming at the very same (x,y) is reported through coll/coll_mask.
// N_CH must be in 2..8.
//
// Ports:
//   clk         in  1          system clock
//   reset_n     in  1          asynchronous active-low reset
//   req         in  N_CH       per-channel plot request, held until ack
//   x_in        in  N_CH*X_W   packed x, channel i at [i*X_W +: X_W]
//   y_in        in  N_CH*Y_W   packed y, same packing
//   colour_in   in  N_CH*C_W   packed colour, same packing
//   hold        in  1          stall, no grants while high
//   ack         out N_CH       one-hot grant, combinational
//   x_out       out X_W        registered pixel x
//   y_out       out Y_W        registered pixel y
//   colour_out  out C_W        registered pixel colour
//   plot        out 1          registered write enable
//   coll        out 1          registered same-pixel collision pulse
//   coll_mask   out N_CH       registered set of channels in that collision
// -----------------------------------------------------------------------------
module plot_arbiter
  import plot_arbiter_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int C_W     = DEF_C_W,
  parameter bit RR_MODE = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH*X_W-1:0] x_in,
  input  logic [N_CH*Y_W-1:0] y_in,
  input  logic [N_CH*C_W-1:0] colour_in,
  input  logic              hold,
  output logic [N_CH-1:0]   ack,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic [C_W-1:0]    colour_out,
  output logic              plot,
  output logic              coll,
  output logic [N_CH-1:0]   coll_mask
);

  localparam int               IDX_W   = idx_width(N_CH);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(N_CH - 1);
  localparam arb_mode_e        MODE    = RR_MODE ? ARB_ROUND_ROBIN : ARB_FIXED;

  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] start;
  logic [N_CH-1:0]  grant;
  logic             granted;
  logic [IDX_W-1:0] win_idx;
  logic [X_W-1:0]   win_x;
  logic [Y_W-1:0]   win_y;
  logic [C_W-1:0]   win_c;
  logic [N_CH-1:0]  hit_mask;

  // Round-robin search begins one past the last winner, wrapping at N_CH-1
  assign start = (last == LAST_CH) ? '0 : last + 1'b1;

  plot_arbiter_rr_pick #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .start (start),
    .mode  (MODE),
    .grant (grant)
  );

  // The grant is forced low during reset as well as during hold, so a reset
  // assertion withdraws the acknowledge without waiting for a clock edge.
  assign ack     = (reset_n && !hold) ? grant : '0;
  assign granted = |ack;

  // Select the winner's index and pixel with an AND-OR mux over the one-hot
  // ack, then mark every requester whose coordinates match the winner's.
  always_comb begin
    win_idx  = '0;
    win_x    = '0;
    win_y    = '0;
    win_c    = '0;
    hit_mask = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ack[k]) begin
        win_idx = IDX_W'(k);
        win_x   = x_in[k*X_W +: X_W];
        win_y   = y_in[k*Y_W +: Y_W];
        win_c   = colour_in[k*C_W +: C_W];
      end
    end
    for (int j = 0; j < N_CH; j++) begin
      hit_mask[j] = ack[j] | (granted & req[j] &
                              (x_in[j*X_W +: X_W] == win_x) &
                              (y_in[j*Y_W +: Y_W] == win_y));
    end
  end

  // Round-robin pointer: moves to the winner only when a grant happens, and
  // resets to the highest channel so channel 0 is searched first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last <= LAST_CH;
    end else if (granted && RR_MODE) begin
      last <= win_idx;
    end
  end

  // Output pixel register: loads the winner one cycle after its ack. Without
  // a grant the coordinates and colour hold while plot/coll drop to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      coll       <= 1'b0;
      coll_mask  <= '0;
    end else if (granted) begin
      x_out      <= win_x;
      y_out      <= win_y;
      colour_out <= win_c;
      plot       <= 1'b1;
      coll       <= ($countones(hit_mask) > 1);
      coll_mask  <= hit_mask;
    end else begin
      plot       <= 1'b0;
      coll       <= 1'b0;
      coll_mask  <= '0;
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_plot_arbiter
// Drives three arbiters: a 2-channel round-robin and a 2-channel fixed
// priority instance sharing one set of inputs, and a 4-channel round-robin
// instance with its own inputs. A behavioural model predicts ack and the
// registered outputs from the arbitration rules; directed scenarios are
// followed by a randomized run with occasional hold and reset pulses.
// -----------------------------------------------------------------------------
module tb_plot_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  logic hold;

  logic [1:0]  req2;
  logic [15:0] x2;
  logic [13:0] y2;
  logic [5:0]  c2;

  logic [3:0]  req4;
  logic [31:0] x4;
  logic [27:0] y4;
  logic [11:0] c4;

  logic [1:0] ack_rr, cm_rr, ack_fp, cm_fp;
  logic [7:0] xo_rr, xo_fp, xo_r4;
  logic [6:0] yo_rr, yo_fp, yo_r4;
  logic [2:0] co_rr, co_fp, co_r4;
  logic       plot_rr, plot_fp, plot_r4, coll_rr, coll_fp, coll_r4;
  logic [3:0] ack_r4, cm_r4;

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       coll;
    logic [7:0] cm;
  } exp_t;

  exp_t e_rr, e_fp, e_r4;
  int   last_rr, last_r4;
  int   checks   = 0;
  int   failures = 0;

  // 10 ns clock
  always #5 clk = ~clk;

  plot_arbiter #(.N_CH(2), .RR_MODE(1'b1)) dut_rr (
    .clk(clk), .reset_n(reset_n), .req(req2), .x_in(x2), .y_in(y2),
    .colour_in(c2), .hold(hold), .ack(ack_rr), .x_out(xo_rr), .y_out(yo_rr),
    .colour_out(co_rr), .plot(plot_rr), .coll(coll_rr), .coll_mask(cm_rr));

  plot_arbiter #(.N_CH(2), .RR_MODE(1'b0)) dut_fp (
    .clk(clk), .reset_n(reset_n), .req(req2), .x_in(x2), .y_in(y2),
    .colour_in(c2), .hold(hold), .ack(ack_fp), .x_out(xo_fp), .y_out(yo_fp),
    .colour_out(co_fp), .plot(plot_fp), .coll(coll_fp), .coll_mask(cm_fp));

  plot_arbiter #(.N_CH(4), .RR_MODE(1'b1)) dut_r4 (
    .clk(clk), .reset_n(reset_n), .req(req4), .x_in(x4), .y_in(y4),
    .colour_in(c4), .hold(hold), .ack(ack_r4), .x_out(xo_r4), .y_out(yo_r4),
    .colour_out(co_r4), .plot(plot_r4), .coll(coll_r4), .coll_mask(cm_r4));

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner among n channels: round-robin scans from last+1 with wrap,
  // fixed priority scans from channel 0. Returns -1 when nobody requests.
  function automatic int pick(input int n, input logic [7:0] r,
                              input int last, input bit rr);
    for (int k = 0; k < n; k++) begin
      int ch;
      ch = rr ? (last + 1 + k) % n : k;
      if (r[ch]) return ch;
    end
    return -1;
  endfunction

  // Registered outputs expected one cycle after a decision with winner win
  function automatic exp_t nextExp(input exp_t prev, input int n, input int win,
                                   input logic [7:0] r, input logic [63:0] xp,
                                   input logic [55:0] yp, input logic [23:0] cp);
    exp_t       e;
    logic [7:0] m;
    e = prev;
    m = '0;
    if (win < 0) begin
      e.plot = 1'b0;
      e.coll = 1'b0;
      e.cm   = '0;
      return e;
    end
    e.plot = 1'b1;
    e.x    = xp[win*8 +: 8];
    e.y    = yp[win*7 +: 7];
    e.c    = cp[win*3 +: 3];
    for (int j = 0; j < n; j++) begin
      if (j == win || (r[j] && xp[j*8 +: 8] == e.x && yp[j*7 +: 7] == e.y))
        m[j] = 1'b1;
    end
    e.cm   = m;
    e.coll = ($countones(m) > 1);
    return e;
  endfunction

  function automatic logic [31:0] onehot(input int w);
    return (w < 0) ? 32'd0 : (32'd1 << w);
  endfunction

  task automatic checkRegs(input string n, input exp_t e, input logic p,
                           input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic co,
                           input logic [7:0] cm);
    checkOutput({n, ".plot"}, 32'(p), 32'(e.plot));
    checkOutput({n, ".x"}, 32'(x), 32'(e.x));
    checkOutput({n, ".y"}, 32'(y), 32'(e.y));
    checkOutput({n, ".colour"}, 32'(c), 32'(e.c));
    checkOutput({n, ".coll"}, 32'(co), 32'(e.coll));
    checkOutput({n, ".coll_mask"}, 32'(cm), 32'(e.cm));
  endtask

  task automatic applyStimulus(input logic rn, input logic h, input logic [1:0] r,
                               input logic [15:0] xx, input logic [13:0] yy,
                               input logic [5:0] cc);
    reset_n = rn;
    hold    = h;
    req2    = r;
    x2      = xx;
    y2      = yy;
    c2      = cc;
  endtask

  // One cycle, entered just after a falling edge with inputs applied: check
  // ack and registered outputs against the model, advance the model to what
  // the next rising edge should produce, then wait for the next falling edge.
  task automatic tick();
    int w_rr, w_fp, w_r4;
    #1;
    if (!reset_n) begin
      e_rr    = '0;
      e_fp    = '0;
      e_r4    = '0;
      last_rr = 1;
      last_r4 = 3;
    end
    w_rr = (reset_n && !hold) ? pick(2, {6'b0, req2}, last_rr, 1'b1) : -1;
    w_fp = (reset_n && !hold) ? pick(2, {6'b0, req2}, 0, 1'b0) : -1;
    w_r4 = (reset_n && !hold) ? pick(4, {4'b0, req4}, last_r4, 1'b1) : -1;
    checkOutput("rr.ack", 32'(ack_rr), onehot(w_rr));
    checkOutput("fp.ack", 32'(ack_fp), onehot(w_fp));
    checkOutput("r4.ack", 32'(ack_r4), onehot(w_r4));
    checkRegs("rr", e_rr, plot_rr, xo_rr, yo_rr, co_rr, coll_rr, 8'(cm_rr));
    checkRegs("fp", e_fp, plot_fp, xo_fp, yo_fp, co_fp, coll_fp, 8'(cm_fp));
    checkRegs("r4", e_r4, plot_r4, xo_r4, yo_r4, co_r4, coll_r4, 8'(cm_r4));
    if (reset_n) begin
      e_rr = nextExp(e_rr, 2, w_rr, {6'b0, req2}, {48'b0, x2}, {42'b0, y2}, {18'b0, c2});
      e_fp = nextExp(e_fp, 2, w_fp, {6'b0, req2}, {48'b0, x2}, {42'b0, y2}, {18'b0, c2});
      e_r4 = nextExp(e_r4, 4, w_r4, {4'b0, req4}, {32'b0, x4}, {28'b0, y4}, {12'b0, c4});
      if (w_rr >= 0) last_rr = w_rr;
      if (w_r4 >= 0) last_r4 = w_r4;
    end
    @(negedge clk);
  endtask

  // Abort guard in case the run ever stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    e_rr = '0; e_fp = '0; e_r4 = '0;
    last_rr = 1; last_r4 = 3;
    req4 = '0; x4 = '0; y4 = '0; c4 = '0;
    applyStimulus(1'b0, 1'b0, 2'b00, '0, '0, '0);
    @(negedge clk);
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 2'b00, '0, '0, '0);
    tick();

    // Single request from channel 0 with pixel (10,20) colour 3
    applyStimulus(1'b1, 1'b0, 2'b01, {8'd0, 8'd10}, {7'd0, 7'd20}, {3'd0, 3'd3});
    #1 checkOutput("t1.ack", 32'(ack_rr), 32'd1);
    tick();
    checkOutput("t1.plot", 32'(plot_rr), 32'd1);
    checkOutput("t1.x", 32'(xo_rr), 32'd10);
    checkOutput("t1.y", 32'(yo_rr), 32'd20);
    checkOutput("t1.colour", 32'(co_rr), 32'd3);
    applyStimulus(1'b1, 1'b0, 2'b00, {8'd0, 8'd10}, {7'd0, 7'd20}, {3'd0, 3'd3});
    tick();
    checkOutput("t1.plot_off", 32'(plot_rr), 32'd0);

    // Both channels requesting continuously
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b11, {8'd5, 8'd1}, {7'd6, 7'd2}, {3'd2, 3'd1});
      #1 checkOutput("t2.fp_ack", 32'(ack_fp), 32'd1);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 2'b10, {8'd5, 8'd1}, {7'd6, 7'd2}, {3'd2, 3'd1});
    #1 checkOutput("t2.fp_ack_ch1", 32'(ack_fp), 32'd2);
    tick();

    // Hold for three cycles, then resume at channel 0 (channel 1 was last)
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 2'b11, {8'd9, 8'd8}, {7'd9, 7'd8}, {3'd6, 3'd5});
      #1 checkOutput("t3.hold_ack", 32'(ack_rr), 32'd0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 2'b11, {8'd9, 8'd8}, {7'd9, 7'd8}, {3'd6, 3'd5});
    #1 checkOutput("t3.resume_ack", 32'(ack_rr), 32'd1);
    tick();
    tick();

    // Both channels aim at pixel (40,30)
    applyStimulus(1'b1, 1'b0, 2'b11, {8'd40, 8'd40}, {7'd30, 7'd30}, {3'd4, 3'd2});
    tick();
    checkOutput("t4.fp_coll", 32'(coll_fp), 32'd1);
    checkOutput("t4.fp_mask", 32'(cm_fp), 32'd3);
    checkOutput("t4.rr_coll", 32'(coll_rr), 32'd1);
    applyStimulus(1'b1, 1'b0, 2'b10, {8'd40, 8'd40}, {7'd30, 7'd30}, {3'd4, 3'd2});
    tick();
    checkOutput("t4.fp_loser_plot", 32'(plot_fp), 32'd1);
    checkOutput("t4.fp_loser_colour", 32'(co_fp), 32'd4);
    checkOutput("t4.fp_loser_coll", 32'(coll_fp), 32'd0);
    applyStimulus(1'b1, 1'b0, 2'b00, {8'd40, 8'd40}, {7'd30, 7'd30}, {3'd4, 3'd2});
    tick();

    // Reset while a pixel is being plotted
    applyStimulus(1'b1, 1'b0, 2'b01, {8'd0, 8'd7}, {7'd0, 7'd8}, {3'd0, 3'd5});
    tick();
    checkOutput("t5.plot_before", 32'(plot_rr), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t5.plot_async", 32'(plot_rr), 32'd0);
    checkOutput("t5.x_async", 32'(xo_rr), 32'd0);
    checkOutput("t5.colour_async", 32'(co_rr), 32'd0);
    checkOutput("t5.ack_async", 32'(ack_rr), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 2'b11, {8'd3, 8'd3}, {7'd3, 7'd3}, {3'd1, 3'd1});
    #1 checkOutput("t5.first_after_reset", 32'(ack_rr), 32'd1);
    tick();

    // Randomized traffic; small coordinate ranges make collisions common
    for (int i = 0; i < 400; i++) begin
      logic [15:0] xx;
      logic [13:0] yy;
      xx = 16'($urandom);
      yy = 14'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        xx = {7'd0, xx[8], 7'd0, xx[0]};
        yy = {6'd0, yy[7], 6'd0, yy[0]};
      end
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0,
                    2'($urandom), xx, yy, 6'($urandom));
      req4 = 4'($urandom);
      x4   = $urandom;
      y4   = 28'($urandom);
      c4   = 12'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        x4 = x4 & 32'h0101_0101;
        y4 = y4 & 28'h020_4081;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Parametrised N-channel arbiter that merges pixel-plot requests from game sub-blocks (snake body, food, score, clear) onto the single VGA adapter write port.
- Replaces the ad-hoc combinational OR/mux between snake and food writers, which drops one writer's pixel whenever two write in the same cycle.
- Every request is held until acknowledged, so no pixel is lost. Round-robin or fixed-priority selection, one registered pixel per cycle, plus same-pixel collision reporting to game logic.

Parameters:
- N_CH, 2, number of requesting channels (2..8).
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- C_W, 3, colour width.
- RR_MODE, 1, 1 = round-robin; 0 = fixed priority with channel 0 highest.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  async active-low reset.
- req  in  N_CH  per-channel plot request, level; held until ack.
- x_in  in  N_CH*X_W  packed x; channel i at [i*X_W +: X_W].
- y_in  in  N_CH*Y_W  packed y, same packing.
- colour_in  in  N_CH*C_W  packed colour, same packing.
- hold  in  1  stall; no grants while high (e.g. VGA clear in progress).
- ack  out  N_CH  one-hot grant, combinational, same cycle as the decision.
- x_out  out  X_W  registered pixel x to VGA adapter.
- y_out  out  Y_W  registered pixel y.
- colour_out  out  C_W  registered colour.
- plot  out  1  registered write enable.
- coll  out  1  registered pulse: the winner's pixel was also requested by another channel.
- coll_mask  out  N_CH  registered set of channels involved in that collision.

Behaviour:
- Reset (async, reset_n=0):
  - plot, coll, coll_mask, x_out, y_out, colour_out = 0.
  - Round-robin pointer last = N_CH-1, so channel 0 wins first.
  - ack is combinational and is 0 while reset_n=0.
- Decision in cycle t:
  - If hold=0 and any req=1, exactly one ack bit is set. Otherwise ack = 0.
  - The acked channel's data is consumed at the rising edge ending cycle t.
  - That channel may drop req or present new data in cycle t+1.
- Latency: plot=1 with the winner's x/y/colour in cycle t+1, exactly one cycle after ack. With no grant in cycle t, plot=0 in t+1 and x/y/colour hold their previous values.
- Throughput: one pixel per cycle. Back-to-back grants to the same channel are allowed when it is the only requester.
- RR_MODE=1:
  - Search starts at last+1 mod N_CH and wraps; the first requester found wins.
  - last is updated to the winner only on a grant.
  - Guarantee: a continuously requesting channel is acked within N_CH grant cycles.
- RR_MODE=0: the lowest-index requester wins; last is unused. Starvation is permitted.
- hold: blocks grants only. A pixel granted in the cycle before hold rises is still output (plot=1) in the next cycle.
- Collision:
  - In a granted cycle t, mask = winner | {j : req[j]=1 and x_j==x_win and y_j==y_win}.
  - coll=1 in t+1 iff popcount(mask) > 1; coll_mask = mask in t+1, else 0.
  - Losers are not cancelled; they are still plotted later.
- Width rules: coordinates are compared and passed unmodified; no clipping or arithmetic.
- req on an out-of-range channel index cannot occur; N_CH outside 2..8 is a configuration error.
- Reset mid-operation: any pending pixel is lost, outputs return to 0 immediately, and ack drops combinationally.

Decomposition:
- Shared package: X_W/Y_W/C_W defaults, screen bounds (160x120), colour constants (BLACK=0, SNAKE, FOOD), and channel index constants (CH_SNAKE=0, CH_FOOD=1).
- Sub-module rr_pick:
  - Inputs: req vector, start index, mode.
  - Output: one-hot grant (rotate, priority-encode, rotate back).
  - Purely combinational; the pointer register lives in plot_arbiter.

Test Plan:
- Reset, then req=2'b01 with ch0 (10,20,3) -> ack=01 in the same cycle; next cycle plot=1, x_out=10, y_out=20, colour_out=3; then plot=0.
- RR_MODE=1, both channels request continuously -> acks 01,10,01,10; plot every cycle alternating ch0/ch1 data.
- RR_MODE=0, both channels request continuously for 4 cycles -> ack=01 every cycle; ch1 never granted until ch0 drops req, then ack=10 next cycle.
- hold=1 for 3 cycles with both req high -> ack=0 and, from the second hold cycle, plot=0. hold falls -> grant resumes at the correct RR position.
- ch0 and ch1 both request pixel (40,30) -> coll=1, coll_mask=11 in t+1; the loser is acked and plotted the following cycle, with coll=0 on its grant if ch0 has dropped req.
- Assert reset_n=0 while plot=1 -> plot, coll, x_out, y_out, colour_out = 0 without waiting for a clock edge. After release, channel 0 is granted first.
